// File: rtl/fwd_pkg.sv
// Shared types for the forwarding/hazard unit: tag-slot layout and latency clamp.
// Slot fields use fixed maximum widths so one struct serves every parameterisation.
package fwd_pkg;
    localparam int FWD_RF       = 0;
    localparam int FWD_MAX_AW   = 8;
    localparam int FWD_MAX_LATW = 4;

    typedef struct packed {
        logic                    valid;
        logic [FWD_MAX_AW-1:0]   rd;
        logic [FWD_MAX_LATW-1:0] lat;
    } fwd_slot_t;

    // Result latency is at least one stage and never beyond the last tracked slot.
    function automatic logic [FWD_MAX_LATW-1:0] clampLat(input logic [FWD_MAX_LATW-1:0] lat,
                                                         input int depth);
        if (lat == '0) return FWD_MAX_LATW'(1);
        if (int'(lat) > depth - 1) return FWD_MAX_LATW'(depth - 1);
        return lat;
    endfunction
endpackage

// File: rtl/fwd_hazard_unit_if.sv
// ID-stage request and EX-stage forwarding response bundle of the hazard unit.
interface fwd_hazard_unit_if #(
    parameter int REG_AW = 5,
    parameter int DEPTH  = 3,
    parameter int CNTW   = 16
);
    localparam int SELW = $clog2(DEPTH);

    logic              pipe_hold;
    logic              flush;
    logic              id_valid;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              id_rs1_used;
    logic              id_rs2_used;
    logic [REG_AW-1:0] id_rd;
    logic              id_reg_write;
    logic [SELW-1:0]   id_lat;
    logic              id_stall;
    logic [SELW-1:0]   ex_fwd_a;
    logic [SELW-1:0]   ex_fwd_b;
    logic [CNTW-1:0]   stall_cnt;

    modport master (
        output pipe_hold, flush, id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
               id_rd, id_reg_write, id_lat,
        input  id_stall, ex_fwd_a, ex_fwd_b, stall_cnt
    );
    modport slave (
        input  pipe_hold, flush, id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
               id_rd, id_reg_write, id_lat,
        output id_stall, ex_fwd_a, ex_fwd_b, stall_cnt
    );
endinterface

// File: rtl/fwd_match.sv
// Youngest-producer priority encoder for one source operand over the tag slots.
module fwd_match
    import fwd_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int DEPTH  = 3
) (
    input  fwd_slot_t                    slots [DEPTH-1],
    input  logic                         srcEn,
    input  logic [REG_AW-1:0]            src,
    output logic [$clog2(DEPTH)-1:0]     sel,
    output logic                         notReady
);
    localparam int SELW = $clog2(DEPTH);

    // Scan oldest to youngest so the lowest-index match overrides.
    always_comb begin
        sel      = SELW'(FWD_RF);
        notReady = 1'b0;
        for (int j = DEPTH - 2; j >= 0; j--) begin
            if (srcEn && slots[j].valid && slots[j].rd == FWD_MAX_AW'(src)) begin
                sel      = SELW'(j + 1);
                notReady = int'(slots[j].lat) > j + 1;
            end
        end
    end
endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding-select and load-use stall generation for an in-order pipeline of DEPTH
// tracked stages, with a saturating hazard-stall counter.
module fwd_hazard_unit
    import fwd_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int DEPTH  = 3,
    parameter int CNTW   = 16
) (
    input logic              clk,
    input logic              rst_n,
    fwd_hazard_unit_if.slave bus
);
    localparam int SELW  = $clog2(DEPTH);
    // The MEM/WB slot is never forwarded from (the register file covers it),
    // so only slots 0..DEPTH-2 are stored.
    localparam int NSLOT = DEPTH - 1;

    fwd_slot_t         slots [NSLOT];
    fwd_slot_t         newSlot;
    logic [REG_AW-1:0] src [2];
    logic [1:0]        srcEn;
    logic [1:0]        notReady;
    logic [SELW-1:0]   sel [2];
    logic              idStall;
    logic              issue;
    logic [SELW-1:0]   exFwdA, exFwdB;
    logic [CNTW-1:0]   stallCnt;

    assign src[0]   = bus.id_rs1;
    assign src[1]   = bus.id_rs2;
    assign srcEn[0] = bus.id_valid & bus.id_rs1_used & (bus.id_rs1 != '0);
    assign srcEn[1] = bus.id_valid & bus.id_rs2_used & (bus.id_rs2 != '0);

    for (genvar g = 0; g < 2; g++) begin : gOp
        fwd_match #(.REG_AW(REG_AW), .DEPTH(DEPTH)) uMatch (
            .slots    (slots),
            .srcEn    (srcEn[g]),
            .src      (src[g]),
            .sel      (sel[g]),
            .notReady (notReady[g])
        );
    end

    assign idStall = bus.id_valid & ~bus.flush & (|notReady);
    assign issue   = bus.id_valid & ~bus.flush & ~idStall;

    // Non-writers and rd=0 enter as bubbles: they can never be producers.
    always_comb begin
        newSlot       = '0;
        newSlot.valid = issue & bus.id_reg_write & (bus.id_rd != '0);
        newSlot.rd    = FWD_MAX_AW'(bus.id_rd);
        newSlot.lat   = clampLat(FWD_MAX_LATW'(bus.id_lat), DEPTH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NSLOT; i++) slots[i] <= '0;
            exFwdA   <= '0;
            exFwdB   <= '0;
            stallCnt <= '0;
        end else if (!bus.pipe_hold) begin
            slots[0] <= newSlot;
            for (int i = 1; i < NSLOT; i++) slots[i] <= slots[i-1];
            exFwdA <= issue ? sel[0] : SELW'(FWD_RF);
            exFwdB <= issue ? sel[1] : SELW'(FWD_RF);
            if (idStall && stallCnt != '1) stallCnt <= stallCnt + CNTW'(1);
        end
    end

    assign bus.id_stall  = idStall;
    assign bus.ex_fwd_a  = exFwdA;
    assign bus.ex_fwd_b  = exFwdB;
    assign bus.stall_cnt = stallCnt;
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench: DUT A (DEPTH=3, CNTW=16) and DUT B (DEPTH=5, CNTW=4).
module tb_fwd_hazard_unit;
    logic clk = 1'b0;
    logic rst_n;
    int   compared = 0;
    int   failed   = 0;

    always #5 clk = ~clk;

    fwd_hazard_unit_if #(.REG_AW(5), .DEPTH(3), .CNTW(16)) ia ();
    fwd_hazard_unit_if #(.REG_AW(5), .DEPTH(5), .CNTW(4))  ib ();

    fwd_hazard_unit #(.REG_AW(5), .DEPTH(3), .CNTW(16)) dutA (.clk(clk), .rst_n(rst_n), .bus(ia));
    fwd_hazard_unit #(.REG_AW(5), .DEPTH(5), .CNTW(4))  dutB (.clk(clk), .rst_n(rst_n), .bus(ib));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idleA();
        ia.pipe_hold = 0; ia.flush = 0; ia.id_valid = 0;
        ia.id_rs1 = 0; ia.id_rs2 = 0; ia.id_rs1_used = 0; ia.id_rs2_used = 0;
        ia.id_rd = 0; ia.id_reg_write = 0; ia.id_lat = 2'd1;
    endtask

    task automatic idleB();
        ib.pipe_hold = 0; ib.flush = 0; ib.id_valid = 0;
        ib.id_rs1 = 0; ib.id_rs2 = 0; ib.id_rs1_used = 0; ib.id_rs2_used = 0;
        ib.id_rd = 0; ib.id_reg_write = 0; ib.id_lat = 3'd1;
    endtask

    task automatic setA(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                        input logic u2, input logic [4:0] rd, input logic wr, input logic [1:0] lat);
        ia.id_valid = 1; ia.id_rs1 = rs1; ia.id_rs1_used = u1; ia.id_rs2 = rs2;
        ia.id_rs2_used = u2; ia.id_rd = rd; ia.id_reg_write = wr; ia.id_lat = lat;
    endtask

    task automatic setB(input logic [4:0] rs1, input logic [4:0] rd, input logic wr,
                        input logic [2:0] lat);
        ib.id_valid = 1; ib.id_rs1 = rs1; ib.id_rs1_used = 1; ib.id_rs2 = 0;
        ib.id_rs2_used = 0; ib.id_rd = rd; ib.id_reg_write = wr; ib.id_lat = lat;
    endtask

    task automatic drain();
        idleA(); idleB();
        repeat (5) tick();
    endtask

    task automatic test_reset();
        idleA(); idleB();
        setA(5'd5, 1, 0, 0, 0, 0, 2'd1);
        rst_n = 0;
        tick(); tick();
        compared++; if (ia.ex_fwd_a !== 2'd0) begin failed++; $display("FAIL reset_fwd_a: got %0d want 0", ia.ex_fwd_a); end
        compared++; if (ia.id_stall !== 1'b0) begin failed++; $display("FAIL reset_stall: got %0b want 0", ia.id_stall); end
        compared++; if (ia.stall_cnt !== 16'd0) begin failed++; $display("FAIL reset_cnt: got %0d want 0", ia.stall_cnt); end
        compared++; if (ib.stall_cnt !== 4'd0) begin failed++; $display("FAIL reset_cnt_b: got %0d want 0", ib.stall_cnt); end
        rst_n = 1;
        drain();
    endtask

    task automatic test_alu_fwd();
        setA(0, 0, 0, 0, 5'd5, 1, 2'd1); tick();
        setA(5'd5, 1, 0, 0, 0, 0, 2'd1); #1;
        compared++; if (ia.id_stall !== 1'b0) begin failed++; $display("FAIL alu_stall: got %0b want 0", ia.id_stall); end
        tick();
        compared++; if (ia.ex_fwd_a !== 2'd1) begin failed++; $display("FAIL alu_fwd_a: got %0d want 1", ia.ex_fwd_a); end
        setA(0, 0, 0, 0, 5'd5, 1, 2'd1); tick();
        idleA(); tick();
        setA(0, 0, 5'd5, 1, 0, 0, 2'd1); #1;
        compared++; if (ia.id_stall !== 1'b0) begin failed++; $display("FAIL gap_stall: got %0b want 0", ia.id_stall); end
        tick();
        compared++; if (ia.ex_fwd_b !== 2'd2) begin failed++; $display("FAIL gap_fwd_b: got %0d want 2", ia.ex_fwd_b); end
        drain();
    endtask

    task automatic test_load_use();
        logic [15:0] base;
        base = ia.stall_cnt;
        setA(0, 0, 0, 0, 5'd7, 1, 2'd2); tick();
        setA(5'd7, 1, 0, 0, 0, 0, 2'd1); #1;
        compared++; if (ia.id_stall !== 1'b1) begin failed++; $display("FAIL lu_stall: got %0b want 1", ia.id_stall); end
        tick();
        compared++; if (ia.ex_fwd_a !== 2'd0) begin failed++; $display("FAIL lu_bubble: got %0d want 0", ia.ex_fwd_a); end
        compared++; if (ia.id_stall !== 1'b0) begin failed++; $display("FAIL lu_stall_end: got %0b want 0", ia.id_stall); end
        compared++; if (ia.stall_cnt !== base + 16'd1) begin failed++; $display("FAIL lu_cnt: got %0d want %0d", ia.stall_cnt, base + 16'd1); end
        tick();
        compared++; if (ia.ex_fwd_a !== 2'd2) begin failed++; $display("FAIL lu_fwd_a: got %0d want 2", ia.ex_fwd_a); end
        drain();
    endtask

    task automatic test_youngest();
        setA(0, 0, 0, 0, 5'd3, 1, 2'd1); tick();
        setA(0, 0, 0, 0, 5'd3, 1, 2'd1); tick();
        setA(5'd3, 1, 0, 0, 0, 0, 2'd1); tick();
        compared++; if (ia.ex_fwd_a !== 2'd1) begin failed++; $display("FAIL young_fwd_a: got %0d want 1", ia.ex_fwd_a); end
        setA(0, 0, 0, 0, 5'd0, 1, 2'd2); tick();
        setA(5'd0, 1, 5'd0, 1, 0, 0, 2'd1); #1;
        compared++; if (ia.id_stall !== 1'b0) begin failed++; $display("FAIL r0_stall: got %0b want 0", ia.id_stall); end
        tick();
        compared++; if (ia.ex_fwd_a !== 2'd0) begin failed++; $display("FAIL r0_fwd_a: got %0d want 0", ia.ex_fwd_a); end
        setA(0, 0, 0, 0, 5'd4, 1, 2'd2); tick();
        setA(5'd4, 1, 5'd4, 1, 0, 0, 2'd1); tick(); tick();
        compared++; if (ia.ex_fwd_a !== 2'd2) begin failed++; $display("FAIL same_fwd_a: got %0d want 2", ia.ex_fwd_a); end
        compared++; if (ia.ex_fwd_b !== 2'd2) begin failed++; $display("FAIL same_fwd_b: got %0d want 2", ia.ex_fwd_b); end
        drain();
    endtask

    task automatic test_flush();
        logic [15:0] base;
        base = ia.stall_cnt;
        setA(0, 0, 0, 0, 5'd7, 1, 2'd2); tick();
        setA(5'd7, 1, 0, 0, 0, 0, 2'd1); ia.flush = 1; #1;
        compared++; if (ia.id_stall !== 1'b0) begin failed++; $display("FAIL fl_stall: got %0b want 0", ia.id_stall); end
        tick();
        compared++; if (ia.stall_cnt !== base) begin failed++; $display("FAIL fl_cnt: got %0d want %0d", ia.stall_cnt, base); end
        compared++; if (ia.ex_fwd_a !== 2'd0) begin failed++; $display("FAIL fl_bubble: got %0d want 0", ia.ex_fwd_a); end
        ia.flush = 0; tick();
        compared++; if (ia.ex_fwd_a !== 2'd2) begin failed++; $display("FAIL fl_fwd_a: got %0d want 2", ia.ex_fwd_a); end
        drain();
    endtask

    task automatic test_hold();
        logic [15:0] base;
        base = ia.stall_cnt;
        setA(0, 0, 0, 0, 5'd6, 1, 2'd1); tick();
        setA(0, 0, 5'd6, 1, 5'd8, 1, 2'd2); tick();
        compared++; if (ia.ex_fwd_b !== 2'd1) begin failed++; $display("FAIL hold_pre_b: got %0d want 1", ia.ex_fwd_b); end
        setA(5'd8, 1, 0, 0, 0, 0, 2'd1); ia.pipe_hold = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            compared++; if (ia.ex_fwd_b !== 2'd1) begin failed++; $display("FAIL hold_fwd_b%0d: got %0d want 1", i, ia.ex_fwd_b); end
            compared++; if (ia.stall_cnt !== base) begin failed++; $display("FAIL hold_cnt%0d: got %0d want %0d", i, ia.stall_cnt, base); end
            compared++; if (ia.id_stall !== 1'b1) begin failed++; $display("FAIL hold_stall%0d: got %0b want 1", i, ia.id_stall); end
        end
        ia.pipe_hold = 0; tick();
        compared++; if (ia.ex_fwd_b !== 2'd0) begin failed++; $display("FAIL rel_bubble: got %0d want 0", ia.ex_fwd_b); end
        compared++; if (ia.stall_cnt !== base + 16'd1) begin failed++; $display("FAIL rel_cnt: got %0d want %0d", ia.stall_cnt, base + 16'd1); end
        tick();
        compared++; if (ia.ex_fwd_a !== 2'd2) begin failed++; $display("FAIL rel_fwd_a: got %0d want 2", ia.ex_fwd_a); end
        drain();
    endtask

    task automatic test_reset_mid_stall();
        setA(0, 0, 0, 0, 5'd7, 1, 2'd2); tick();
        setA(5'd7, 1, 0, 0, 0, 0, 2'd1); #1;
        compared++; if (ia.id_stall !== 1'b1) begin failed++; $display("FAIL rm_pre: got %0b want 1", ia.id_stall); end
        rst_n = 0; #1;
        compared++; if (ia.id_stall !== 1'b0) begin failed++; $display("FAIL rm_stall: got %0b want 0", ia.id_stall); end
        compared++; if (ia.stall_cnt !== 16'd0) begin failed++; $display("FAIL rm_cnt: got %0d want 0", ia.stall_cnt); end
        #2; rst_n = 1; #1;
        compared++; if (ia.id_stall !== 1'b0) begin failed++; $display("FAIL rm_after: got %0b want 0", ia.id_stall); end
        tick();
        compared++; if (ia.ex_fwd_a !== 2'd0) begin failed++; $display("FAIL rm_fwd_a: got %0d want 0", ia.ex_fwd_a); end
        drain();
    endtask

    task automatic test_depth5();
        int n;
        logic [2:0] lats [2];
        lats[0] = 3'd4; lats[1] = 3'd7;   // 7 clamps to DEPTH-1 = 4
        for (int k = 0; k < 2; k++) begin
            setB(0, 5'd10, 1, lats[k]); tick();
            setB(5'd10, 0, 0, 3'd1); #1;
            n = 0;
            for (int i = 0; i < 8 && ib.id_stall; i++) begin n++; tick(); end
            compared++; if (n !== 3) begin failed++; $display("FAIL d5_stalls%0d: got %0d want 3", k, n); end
            tick();
            compared++; if (ib.ex_fwd_a !== 3'd4) begin failed++; $display("FAIL d5_fwd_a%0d: got %0d want 4", k, ib.ex_fwd_a); end
            compared++; if (ib.stall_cnt !== 4'(3 * (k + 1))) begin failed++; $display("FAIL d5_cnt%0d: got %0d want %0d", k, ib.stall_cnt, 3 * (k + 1)); end
        end
        drain();
    endtask

    task automatic test_saturate();
        // Self-dependent chain: 3 stalls per 4 cycles, well beyond 2^CNTW + 5 stalls.
        setB(5'd9, 5'd9, 1, 3'd4);
        repeat (40) tick();
        compared++; if (ib.stall_cnt !== 4'hF) begin failed++; $display("FAIL sat_cnt: got %0h want f", ib.stall_cnt); end
        drain();
    endtask

    initial begin
        test_reset();
        test_alu_fwd();
        test_load_use();
        test_youngest();
        test_flush();
        test_hold();
        test_reset_mid_stall();
        test_depth5();
        test_saturate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end
endmodule
